// File: rtl/wfifo_skid_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wfifo_skid_writer_pkg
// Purpose  : Shared types and helpers for the async-FIFO write-side skid
//            writer: occupancy encoding and a saturating increment.
// Revision : 1.0 - initial release
// ============================================================================
package wfifo_skid_writer_pkg;

    // Skid buffer occupancy; h0 is valid in ONE and TWO, h1 only in TWO.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    // Widest statistics counter the helper below can service.
    localparam int c_SAT_MAXW = 32;

    // Increment that sticks at max_val instead of wrapping.
    function automatic logic [c_SAT_MAXW-1:0] sat_inc(
        input logic [c_SAT_MAXW-1:0] val,
        input logic [c_SAT_MAXW-1:0] max_val
    );
        return (val >= max_val) ? val : val + 1'b1;
    endfunction

endpackage : wfifo_skid_writer_pkg
`default_nettype wire

// File: rtl/wfifo_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : wfifo_sat_counter
// Purpose  : CNTW-wide up counter with enable that saturates at all-ones,
//            cleared asynchronously by an active-high reset.
// Revision : 1.0 - initial release
// ============================================================================
module wfifo_sat_counter
    import wfifo_skid_writer_pkg::*;
#(
    parameter int CNTW = 16   // 1..32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_en,
    output logic [CNTW-1:0] o_cnt
);

    localparam logic [c_SAT_MAXW-1:0] c_CNT_MAX =
        c_SAT_MAXW'((64'd1 << CNTW) - 64'd1);

    logic [CNTW-1:0]       r_cnt;
    logic [c_SAT_MAXW-1:0] w_cnt_ext;
    logic [c_SAT_MAXW-1:0] w_cnt_inc;

    assign w_cnt_ext = c_SAT_MAXW'(r_cnt);
    assign w_cnt_inc = sat_inc(w_cnt_ext, c_CNT_MAX);

    // The incremented value never exceeds c_CNT_MAX, so the bits above
    // CNTW are always zero and are intentionally dropped.
    generate
        if (CNTW < c_SAT_MAXW) begin : g_hi_bits
            logic [c_SAT_MAXW-CNTW-1:0] w_unused_hi;
            assign w_unused_hi = w_cnt_inc[c_SAT_MAXW-1:CNTW];
        end
    endgenerate

    // Count enabled cycles, holding at the maximum once reached.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_cnt_inc[CNTW-1:0];
        end
    end

    assign o_cnt = r_cnt;

endmodule : wfifo_sat_counter
`default_nettype wire

// File: rtl/wfifo_skid_writer.sv
`default_nettype none
// ============================================================================
// Module   : wfifo_skid_writer
// Purpose  : Write-side front end of the async FIFO. Turns a valid/ready
//            stream into winc/wdata through a 2-entry skid buffer, honouring
//            wfull (and optionally awfull), with saturating debug counters.
// Revision : 1.0 - initial release
// ============================================================================
module wfifo_skid_writer
    import wfifo_skid_writer_pkg::*;
#(
    parameter int DSIZE      = 8,
    parameter int USE_AWFULL = 0,
    parameter int CNTW       = 16
) (
    input  logic             wclk,
    input  logic             wrst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DSIZE-1:0] s_data,
    output logic             winc,
    output logic [DSIZE-1:0] wdata,
    input  logic             wfull,
    input  logic             awfull,
    output logic [CNTW-1:0]  acc_cnt,
    output logic [CNTW-1:0]  stall_cnt
);

    occ_t             r_occ;
    logic [DSIZE-1:0] r_h0;      // oldest word, always what wdata shows
    logic [DSIZE-1:0] r_h1;      // second word, only meaningful in TWO
    logic             r_winc;    // registered (r_occ != EMPTY)
    logic             r_space;   // registered (r_occ != TWO)

    logic w_aw_block;
    logic w_push;
    logic w_pop;
    logic w_stall;

    // awfull is a registered flag, so gating s_ready with it keeps s_ready
    // free of any path from s_valid.
    assign w_aw_block = (USE_AWFULL != 0) & awfull;
    assign s_ready    = r_space & ~w_aw_block;
    assign w_push     = s_valid & s_ready;
    // winc stays high under wfull; the word only leaves when it really lands.
    assign w_pop      = r_winc & ~wfull;
    assign w_stall    = r_winc & wfull;

    // Occupancy FSM with its data entries and registered strobes.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_occ   <= EMPTY;
            r_h0    <= '0;
            r_h1    <= '0;
            r_winc  <= 1'b0;
            r_space <= 1'b1;
        end else begin
            case (r_occ)
                EMPTY: begin
                    if (w_push) begin
                        r_occ  <= ONE;
                        r_h0   <= s_data;
                        r_winc <= 1'b1;
                    end
                end
                ONE: begin
                    if (w_push && !w_pop) begin
                        r_occ   <= TWO;
                        r_h1    <= s_data;
                        r_space <= 1'b0;
                    end else if (w_pop && !w_push) begin
                        r_occ  <= EMPTY;
                        r_winc <= 1'b0;
                    end else if (w_push && w_pop) begin
                        r_h0 <= s_data;
                    end
                end
                TWO: begin
                    // s_ready is low here, so only a pop can happen.
                    if (w_pop) begin
                        r_occ   <= ONE;
                        r_h0    <= r_h1;
                        r_space <= 1'b1;
                    end
                end
                default: begin
                    r_occ   <= EMPTY;
                    r_winc  <= 1'b0;
                    r_space <= 1'b1;
                end
            endcase
        end
    end

    assign winc  = r_winc;
    assign wdata = r_h0;

    wfifo_sat_counter #(
        .CNTW (CNTW)
    ) u_acc_cnt (
        .clk   (wclk),
        .rst   (wrst),
        .i_en  (w_push),
        .o_cnt (acc_cnt)
    );

    wfifo_sat_counter #(
        .CNTW (CNTW)
    ) u_stall_cnt (
        .clk   (wclk),
        .rst   (wrst),
        .i_en  (w_stall),
        .o_cnt (stall_cnt)
    );

endmodule : wfifo_skid_writer
`default_nettype wire

// File: tb/tb_wfifo_skid_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_wfifo_skid_writer
// Purpose  : Directed and scoreboarded bench for wfifo_skid_writer. Instance
//            A uses defaults; instance B uses USE_AWFULL=1, CNTW=4 and shares
//            every input with A.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wfifo_skid_writer;

    logic       wclk;
    logic       wrst;
    logic       s_valid;
    logic [7:0] s_data;
    logic       wfull;
    logic       awfull;

    logic        s_ready_a, winc_a;
    logic [7:0]  wdata_a;
    logic [15:0] acc_a, stall_a;

    logic        s_ready_b, winc_b;
    logic [7:0]  wdata_b;
    logic [3:0]  acc_b, stall_b;

    int n_total = 0;
    int n_bad   = 0;

    wfifo_skid_writer #(
        .DSIZE (8), .USE_AWFULL (0), .CNTW (16)
    ) dut_a (
        .wclk (wclk), .wrst (wrst),
        .s_valid (s_valid), .s_ready (s_ready_a), .s_data (s_data),
        .winc (winc_a), .wdata (wdata_a),
        .wfull (wfull), .awfull (awfull),
        .acc_cnt (acc_a), .stall_cnt (stall_a)
    );

    wfifo_skid_writer #(
        .DSIZE (8), .USE_AWFULL (1), .CNTW (4)
    ) dut_b (
        .wclk (wclk), .wrst (wrst),
        .s_valid (s_valid), .s_ready (s_ready_b), .s_data (s_data),
        .winc (winc_b), .wdata (wdata_b),
        .wfull (wfull), .awfull (awfull),
        .acc_cnt (acc_b), .stall_cnt (stall_b)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge wclk);
        #1;
    endtask

    logic [7:0] q[$];
    logic       push, pop, acc_last;
    int         n_push;

    initial begin
        wrst = 1'b1; s_valid = 1'b0; s_data = 8'h00; wfull = 1'b0; awfull = 1'b0;
        #3;
        check("rst_winc",    32'(winc_a),    32'd0);
        check("rst_wdata",   32'(wdata_a),   32'd0);
        check("rst_ready",   32'(s_ready_a), 32'd1);
        check("rst_acc",     32'(acc_a),     32'd0);
        check("rst_stall",   32'(stall_a),   32'd0);
        tick; tick;
        wrst = 1'b0;

        // ---- streaming at full rate ----
        for (int i = 1; i <= 16; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(i);
            tick;
            check("stream_winc",  32'(winc_a),  32'd1);
            check("stream_wdata", 32'(wdata_a), 32'(i));
        end
        s_valid = 1'b0;
        tick;
        check("stream_idle_winc", 32'(winc_a),  32'd0);
        check("stream_acc",       32'(acc_a),   32'd16);
        check("stream_stall",     32'(stall_a), 32'd0);
        check("sat_acc_b",        32'(acc_b),   32'd15);

        // ---- wfull backpressure ----
        s_valid = 1'b1; s_data = 8'hA0;
        tick;                               // A0 accepted
        wfull = 1'b1; s_data = 8'hA1;
        tick;                               // A1 accepted, buffer full
        check("full_ready",  32'(s_ready_a), 32'd0);
        check("full_wdata0", 32'(wdata_a),   32'hA0);
        s_data = 8'hA2;
        repeat (4) tick;
        check("full_hold_wdata", 32'(wdata_a),   32'hA0);
        check("full_hold_winc",  32'(winc_a),    32'd1);
        check("full_hold_ready", 32'(s_ready_a), 32'd0);
        check("full_stall",      32'(stall_a),   32'd5);
        check("full_stall_b",    32'(stall_b),   32'd5);
        wfull = 1'b0;
        tick;                               // A0 written
        check("drain_wdata1", 32'(wdata_a),   32'hA1);
        check("drain_ready",  32'(s_ready_a), 32'd1);
        tick;                               // A1 written, A2 accepted
        check("drain_wdata2", 32'(wdata_a),   32'hA2);
        s_valid = 1'b0;
        tick;                               // A2 written
        check("drain_idle", 32'(winc_a), 32'd0);
        check("drain_acc",  32'(acc_a),  32'd19);
        check("sat_acc_b2", 32'(acc_b),  32'd15);

        // ---- almost-full early backpressure (instance B) ----
        s_valid = 1'b1; s_data = 8'h30;
        tick;
        s_data = 8'h31;
        tick;
        check("aw_pre_wdata", 32'(wdata_b), 32'h31);
        check("aw_pre_winc",  32'(winc_b),  32'd1);
        awfull = 1'b1; s_data = 8'h32;
        #1;
        check("aw_ready_c1",  32'(s_ready_b), 32'd0);
        check("aw_ready_a",   32'(s_ready_a), 32'd1);
        tick;                               // 0x31 still written
        check("aw_ready_c2",  32'(s_ready_b), 32'd0);
        check("aw_drained",   32'(winc_b),    32'd0);
        tick;
        check("aw_ready_c3",  32'(s_ready_b), 32'd0);
        tick;
        awfull = 1'b0;
        #1;
        check("aw_ready_back", 32'(s_ready_b), 32'd1);
        tick;
        check("aw_next_wdata", 32'(wdata_b), 32'h32);
        check("aw_next_winc",  32'(winc_b),  32'd1);
        s_valid = 1'b0;

        // ---- reset while holding two words ----
        wrst = 1'b1; #1; wrst = 1'b0;
        tick;
        wfull = 1'b1; s_valid = 1'b1; s_data = 8'h50;
        tick;
        s_data = 8'h51;
        tick;
        check("mid_two_ready", 32'(s_ready_a), 32'd0);
        check("mid_two_acc",   32'(acc_a),     32'd2);
        wrst = 1'b1;
        #1;
        check("mid_rst_winc",  32'(winc_a),    32'd0);
        check("mid_rst_ready", 32'(s_ready_a), 32'd1);
        check("mid_rst_acc",   32'(acc_a),     32'd0);
        check("mid_rst_stall", 32'(stall_a),   32'd0);
        tick;
        wrst = 1'b0; wfull = 1'b0; s_data = 8'h52;
        tick;
        check("post_rst_wdata", 32'(wdata_a), 32'h52);
        check("post_rst_winc",  32'(winc_a),  32'd1);
        check("post_rst_acc",   32'(acc_a),   32'd1);
        s_valid = 1'b0;
        tick;

        // ---- random traffic against a scoreboard (instance A) ----
        wrst = 1'b1; #1; wrst = 1'b0;
        tick;
        acc_last = 1'b0;
        n_push   = 0;
        for (int c = 0; c < 10000; c++) begin
            if (c < 9980) begin
                // An offered word that was not taken must be held.
                if (!(s_valid && !acc_last)) begin
                    s_valid = ($urandom % 4) != 0;
                    s_data  = 8'($urandom);
                end
                wfull = ($urandom % 3) == 0;
            end else begin
                s_valid = 1'b0;
                wfull   = 1'b0;
            end
            @(negedge wclk);
            push = s_valid && s_ready_a;
            pop  = winc_a && !wfull;
            check("rnd_ready", 32'(s_ready_a), 32'(q.size() != 2));
            check("rnd_winc",  32'(winc_a),    32'(q.size() != 0));
            if (pop) begin
                if (q.size() == 0) check("rnd_spurious_write", 32'd1, 32'd0);
                else               check("rnd_wdata", 32'(wdata_a), 32'(q.pop_front()));
            end
            if (push) begin
                q.push_back(s_data);
                n_push++;
            end
            acc_last = push;
            tick;
        end
        check("rnd_left_over", 32'(q.size()), 32'd0);
        check("rnd_acc",       32'(acc_a),    32'(n_push));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_wfifo_skid_writer
`default_nettype wire
